// File: rtl/matrix_mac_pkg.sv
`default_nettype none
// ============================================================================
// matrix_mac_pkg: shared FSM state type, default widths and saturating add.
// Rev 1.0
// ============================================================================
package matrix_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_e;

  localparam int c_data_width = 8;
  localparam int c_acc_width  = 32;
  localparam int c_lanes      = 4;
  localparam int c_len_width  = 8;
  localparam int c_sat_w      = 64;

  // Operands are sign-extended to c_sat_w bits, so the sum itself never wraps
  // for any width up to 62 bits. The MSB of the result is the clamp flag.
  function automatic logic [c_sat_w:0] sat_add(
    input logic signed [c_sat_w-1:0] acc,
    input logic signed [c_sat_w-1:0] inc,
    input int                        width
  );
    logic signed [c_sat_w-1:0] sum;
    logic signed [c_sat_w-1:0] max_v;
    logic signed [c_sat_w-1:0] min_v;
    sum   = acc + inc;
    max_v = $signed((64'd1 << (width - 1)) - 64'd1);
    min_v = ~max_v;
    if (sum > max_v) begin
      return {1'b1, max_v};
    end else if (sum < min_v) begin
      return {1'b1, min_v};
    end
    return {1'b0, sum};
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_mac_lane.sv
`default_nettype none
// ============================================================================
// matrix_mac_lane: one signed multiply-accumulate lane with sticky clamp flag.
// Rev 1.0
// ============================================================================
module matrix_mac_lane
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int ACC_WIDTH  = c_acc_width
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  zero,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  sat
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  assign w_prod     = $signed(a) * $signed(b);
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign acc        = r_acc;

`ifdef MATRIX_MAC_TILE_SATURATE_EN
  logic [c_sat_w:0] w_sat_res;
  logic             w_unused_sat_hi;
  logic             r_sat;

  assign w_sat_res       = sat_add(c_sat_w'(r_acc), c_sat_w'(w_prod_ext), ACC_WIDTH);
  assign w_unused_sat_hi = ^w_sat_res[c_sat_w-1:ACC_WIDTH];
  assign sat             = r_sat;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (zero) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (en) begin
      r_acc <= w_sat_res[ACC_WIDTH-1:0];
      if (w_sat_res[c_sat_w]) begin
        r_sat <= 1'b1;
      end
    end
  end
`else
  assign sat = 1'b0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (zero) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/matrix_mac_tile.sv
`default_nettype none
// ============================================================================
// matrix_mac_tile: LANES-wide signed dot-product tile with valid/ready ports.
// Build option MATRIX_MAC_TILE_SATURATE_EN selects saturating lanes. Rev 1.0
// ============================================================================
module matrix_mac_tile
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int ACC_WIDTH  = c_acc_width,
  parameter int LANES      = c_lanes,
  parameter int LEN_WIDTH  = c_len_width
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        vec_len,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] a_data,
  input  logic [LANES*DATA_WIDTH-1:0] b_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  out_data,
  output logic [LANES-1:0]            out_sat
);

  mac_state_e           r_state;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] w_cnt_nxt;
  logic                 w_accept;
  logic                 w_consume;
  logic                 w_zero;

  assign busy      = (r_state != IDLE);
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);

  assign w_cnt_nxt = r_cnt + LEN_WIDTH'(1);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;
  // Lanes are also zeroed on start so a zero-length operation reports zeros.
  assign w_zero    = clear || w_consume || ((r_state == IDLE) && start);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len <= vec_len;
            r_cnt <= '0;
            if (vec_len == '0) begin
              r_state <= HOLD;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    matrix_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clock(clock),
      .reset(reset),
      .zero (w_zero),
      .en   (w_accept),
      .a    (a_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .b    (b_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .acc  (out_data[i*ACC_WIDTH +: ACC_WIDTH]),
      .sat  (out_sat[i])
    );
  end

endmodule
`default_nettype wire

// File: doc/matrix_mac_tile.md
# matrix_mac_tile

Parametrised multi-lane multiply-accumulate tile for matrix multiplication. Each of `LANES` independent lanes accumulates a signed dot product of programmable length `vec_len` from a valid/ready operand stream, then presents all lane results on a valid/ready result port. This is the second-generation matrix MAC datapath. It adds lane parallelism, a programmable vector length, handshakes, and optional saturation, and sits between the operand fetch buffers and the result writeback.

## Interface
- `DATA_WIDTH`, 8: width of each signed operand element.
- `ACC_WIDTH`, 32: width of each signed lane accumulator; must be ≥ 2*`DATA_WIDTH`.
- `LANES`, 4: number of parallel MAC lanes.
- `LEN_WIDTH`, 8: width of `vec_len`.
- `clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `clear`  in  1  synchronous abort; zeroes accumulators and returns the FSM to IDLE.
- `start`  in  1  begins an operation; honoured only in IDLE.
- `vec_len`  in  `LEN_WIDTH`  number of beats per operation; latched on an accepted `start`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `in_valid`  in  1  the operand beat is valid.
- `in_ready`  out  1  high exactly when the FSM is in ACCUM.
- `a_data`  in  `LANES`*`DATA_WIDTH`  packed signed A elements; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `b_data`  in  `LANES`*`DATA_WIDTH`  packed signed B elements, same packing as `a_data`.
- `out_valid`  out  1  the result is held, registered.
- `out_ready`  in  1  the consumer accepts the result.
- `out_data`  out  `LANES`*`ACC_WIDTH`  packed lane accumulators.
- `out_sat`  out  `LANES`  per-lane sticky saturation flags.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - `start`=1 with `vec_len`≠0: latch `vec_len`, clear the beat counter, go to ACCUM.
  - `start`=1 with `vec_len`=0: go directly to HOLD with zero results.
- ACCUM:
  - A beat is accepted when `in_valid` && `in_ready`.
  - On each accepted beat, every lane i performs acc_i += sext(a_i*b_i). The product is a full 2*`DATA_WIDTH` signed value.
  - The beat counter increments on each accepted beat.
  - When the beat counter reaches `vec_len` (that is, on the beat numbered `vec_len`), go to HOLD.
  - Cycles with `in_valid`=0 are stalls; no state changes.
- HOLD:
  - `out_valid`=1 and `out_data` is stable.
  - On `out_valid` && `out_ready`, all accumulators and `out_sat` are zeroed and the FSM goes to IDLE.
- `start` outside IDLE is ignored.
- `clear` has priority over `start`, over beat acceptance, and over the output handshake in every state:
  - all accumulators and `out_sat` are zeroed;
  - the FSM goes to IDLE;
  - `out_valid` drops on the next cycle.
- Default arithmetic: two's-complement wrap modulo 2^`ACC_WIDTH`; `out_sat` is held at 0.

## Timing
- Reset (`reset`=0 at an edge) gives: `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, FSM in IDLE.
- Reset has priority over `clear` and over every other input.
- `start` accepted at edge T:
  - `busy`=1 and `in_ready`=1 from T+1;
  - with `vec_len`=0 instead: `out_valid`=1 from T+1.
- Last beat accepted at edge T: `out_valid`=1 and `in_ready`=0 from T+1.
  - Latency from the final beat to the result is 1 cycle.
- Result consumed at edge T: `out_valid`=0 and `busy`=0 from T+1.
- The earliest new `start` is accepted at T+1. Minimum operation period is `vec_len`+2 cycles.
- `in_ready` and `out_valid` are registered-state decodes. They have no combinational dependency on `in_valid` or `out_ready`.

## Configuration
- Macro: `MATRIX_MAC_TILE_SATURATE_EN`.
- When defined, each lane accumulates with saturation:
  - a sum above 2^(`ACC_WIDTH`-1)-1 clamps to that maximum;
  - a sum below -2^(`ACC_WIDTH`-1) clamps to that minimum;
  - the lane's `out_sat` bit sets on the clamp and stays set until consume, `clear`, or reset.
- When undefined, arithmetic wraps and `out_sat` is tied to 0.

## Structure
- Shared package `matrix_mac_pkg` contains:
  - FSM state enum `mac_state_e` (IDLE, ACCUM, HOLD);
  - default-width localparams;
  - a `sat_add` function used by the saturating build.
- One sub-module, `matrix_mac_lane`: single-lane multiplier, accumulator, and saturation flag, instantiated `LANES` times in a generate loop.
- The top level owns the FSM, the beat counter, and the handshakes.

## Test plan
- Reset: `reset`=0 for 2 cycles -> all outputs 0, `busy`=0.
- Basic case, `LANES`=4, `vec_len`=3, lane i uses a=i+1 and b=2 on every beat, no stalls:
  - `out_data` lanes = 6, 12, 18, 24;
  - `out_valid` asserted exactly 1 cycle after the 3rd beat.
- Signed operands with stalls: lane 0 beats (a, b) = (-128, -128), (127, -1), with `in_valid` gaps between beats -> lane 0 = 16257; the count is unaffected by stalls.
- Backpressure and zero length:
  - hold `out_ready`=0 for 5 cycles in HOLD -> `out_data` stable and `in_ready`=0 throughout; `start` during HOLD is ignored;
  - `vec_len`=0 -> `out_valid`=1 next cycle with all lanes 0.
- `clear` mid-ACCUM after 2 beats of a `vec_len`=4 operation:
  - next cycle IDLE with accumulators 0;
  - a fresh operation then produces results free of stale contributions.
- Overflow, `ACC_WIDTH`=16, `DATA_WIDTH`=8, lane 0 beats (127, 127) ×3:
  - with the macro: lane 0 = 32767 and `out_sat`[0]=1;
  - without the macro: lane 0 = 48387 - 65536 = -17149 and `out_sat`=0.
